// File: rtl/sub_pkg.sv
// Shared definitions for the sequential slice-wise subtractor: FSM states,
// default geometry and the slice-counter width helper.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 64;
  localparam int SLICE_DEF = 16;

  // Counter needs at least one bit even when a single slice covers the word.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NSLICE = WIDTH_DEF / SLICE_DEF;
  localparam int CNT_W  = cnt_w(NSLICE);

endpackage

// File: rtl/sub_slice.sv
// Combinational SLICE-bit subtractor cell: d = a - b - bin, bout set when the
// unsigned result goes negative.
module sub_slice
  import sub_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic [SLICE:0] diff;

  // The extra top bit of the SLICE+1 wide difference is the borrow.
  assign diff = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
  assign d    = diff[SLICE-1:0];
  assign bout = diff[SLICE];

endmodule

// File: rtl/full_subtractor_64bit_seq.sv
// Multi-cycle subtractor D = A - B - Bi, one slice per clock LSB first, with a
// start/busy/done handshake. A single sub_slice cell is time-multiplexed.
module full_subtractor_64bit_seq
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = cnt_w(NSL);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic             brw_q, bo_q;
  logic [CW-1:0]    cnt_q;
  logic [SLICE-1:0] a_s, b_s, d_s;
  logic             bout_s;
  logic             last;

  assign last = (cnt_q == CW'(NSL - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select the operand slice addressed by the counter.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int k = 0; k < NSL; k++) begin
      if (cnt_q == CW'(k)) begin
        a_s = a_q[k*SLICE +: SLICE];
        b_s = b_q[k*SLICE +: SLICE];
      end
    end
  end

  sub_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_s),
    .b    (b_s),
    .bin  (brw_q),
    .d    (d_s),
    .bout (bout_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      bo_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        a_q   <= A;
        b_q   <= B;
        brw_q <= Bi;
        bo_q  <= 1'b0;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        for (int k = 0; k < NSL; k++) begin
          if (cnt_q == CW'(k)) d_q[k*SLICE +: SLICE] <= d_s;
        end
        brw_q <= bout_s;
        cnt_q <= cnt_q + CW'(1);
        if (last) bo_q <= bout_s;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign D    = d_q;
  assign Bo   = bo_q;

endmodule

// File: tb/tb_full_subtractor_64bit_seq.sv
// Scoreboard bench for full_subtractor_64bit_seq: directed vectors push
// expected results, a negedge monitor pops and compares on every done pulse.
module tb_full_subtractor_64bit_seq;

  typedef struct packed {
    logic [63:0] d;
    logic        bo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] A = '0, B = '0;
  logic        Bi = 1'b0;
  logic        busy, done, Bo;
  logic [63:0] D;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  full_subtractor_64bit_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bi    (Bi),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bo    (Bo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("D", D, e.d);
        chk("Bo", {63'd0, Bo}, {63'd0, e.bo});
      end
    end
  end

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic bi,
                       input logic [63:0] exp_d, input logic exp_bo, input bit poke);
    int n;
    int busy_cnt;
    logic [64:0] rt;
    @(negedge clk);
    A = a; B = b; Bi = bi; start = 1'b1;
    sb_q.push_back('{d: exp_d, bo: exp_bo});
    n = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      // Disturb the inputs after acceptance; start pulses while busy must be ignored.
      A = 64'd5; B = 64'd10; Bi = 1'b1;
      start = (poke && (n == 1 || n == 2)) ? 1'b1 : 1'b0;
      if (busy) busy_cnt++;
    end while (!done && n < 20);
    if (!done) begin
      chk("done_timeout", 64'd1, 64'd0);
    end else begin
      chk("latency", 64'(n), 64'd5);
      chk("busy_cycles", 64'(busy_cnt), 64'd4);
      rt = {1'b0, D} + {1'b0, b} + {64'd0, bi};
      chk("round_trip", rt[63:0], a);
      chk("round_trip_carry", {63'd0, rt[64]}, {63'd0, Bo});
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("idle_after_done", {62'd0, busy, done}, 64'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_outputs", {62'd0, busy, done}, 64'd0);
    chk("reset_D", D, 64'd0);
    chk("reset_Bo", {63'd0, Bo}, 64'd0);

    do_op(64'd1, 64'd0, 1'b0, 64'd1, 1'b0, 1'b0);
    do_op(64'd1, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    do_op(64'd145310, 64'd79845, 1'b0, 64'd65465, 1'b0, 1'b0);
    do_op(64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    do_op(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    do_op(64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    do_op(64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    do_op(64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 1'b1, 64'd0, 1'b0, 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b0, 1'b0);
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0);
    do_op(64'd100, 64'd30, 1'b0, 64'd70, 1'b0, 1'b1);

    // Abort mid-RUN: no done may follow, outputs must be cleared.
    @(negedge clk);
    A = 64'h0000_0000_0009_0009; B = 64'd4; Bi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
    chk("abort_D", D, 64'd0);
    chk("abort_Bo", {63'd0, Bo}, 64'd0);
    repeat (8) @(negedge clk);

    do_op(64'd9, 64'd4, 1'b0, 64'd5, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
